// File: rtl/mux8_ser_pkg.sv
// Shared types and helpers for the 8:1 mux serializer controller.
package mux8_ser_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int DATA_W = 8;
  localparam int SEL_W  = 3;

  // Select value a frame starts from (and rests at while idle).
  function automatic logic [SEL_W-1:0] start_sel(input logic msb_first);
    return msb_first ? 3'd7 : 3'd0;
  endfunction

endpackage

// File: rtl/bit_timer.sv
// Clock counter marking the first and last clock of each bit period.
module bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic restart,
  output logic first_o,
  output logic last_o
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_r;

  assign first_o = en && (cnt_r == '0);
  assign last_o  = en && (cnt_r == LAST_CNT);

  // Count 0..C-1 while enabled, wrapping so back-to-back bits need no restart.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (restart) begin
      cnt_r <= '0;
    end else if (last_o) begin
      cnt_r <= '0;
    end else if (en) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/mux8_serializer_ctrl.sv
// Latches a byte and steps the select of a downstream 8:1 mux through all
// eight positions, producing framing, per-bit strobe and done pulses.
module mux8_serializer_ctrl
  import mux8_ser_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter bit MSB_FIRST    = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] data_o,
  output logic [SEL_W-1:0]  sel_o,
  output logic              frame_o,
  output logic              bit_strobe_o,
  output logic              done_o
);

  localparam logic [SEL_W-1:0] START = start_sel(MSB_FIRST);

  state_e           state_r;
  logic [SEL_W-1:0] bit_cnt_r;
  logic [SEL_W-1:0] bit_cnt_next_s;
  logic             first_s;
  logic             last_s;
  logic             in_ready_s;
  logic             accept_s;
  logic             frame_end_s;

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk    (clk),
    .rst    (rst),
    .en     (state_r == SHIFT),
    .restart(accept_s),
    .first_o(first_s),
    .last_o (last_s)
  );

  assign in_ready     = in_ready_s;
  assign bit_strobe_o = first_s;

  // Handshake, end-of-frame detection and next bit index.
  always_comb begin
    frame_end_s = (state_r == SHIFT) && last_s && (bit_cnt_r == 3'd7);
    if (rst) begin
      in_ready_s = 1'b0;
    end else if (state_r == IDLE) begin
      in_ready_s = 1'b1;
    end else begin
      in_ready_s = frame_end_s;
    end
    accept_s = in_valid && in_ready_s;
    if (accept_s) begin
      bit_cnt_next_s = 3'd0;
    end else if ((state_r == SHIFT) && last_s) begin
      bit_cnt_next_s = bit_cnt_r + 3'd1;  // 7 wraps to 0 so sel rests at START
    end else begin
      bit_cnt_next_s = bit_cnt_r;
    end
  end

  // Frame FSM with registered data, select, frame and done outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      data_o    <= 8'h00;
      sel_o     <= START;
      frame_o   <= 1'b0;
      done_o    <= 1'b0;
      bit_cnt_r <= 3'd0;
    end else begin
      done_o    <= frame_end_s;
      bit_cnt_r <= bit_cnt_next_s;
      sel_o     <= MSB_FIRST ? ~bit_cnt_next_s : bit_cnt_next_s;
      if (accept_s) begin
        data_o <= in_data;
      end else begin
        data_o <= data_o;
      end
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            state_r <= SHIFT;
            frame_o <= 1'b1;
          end else begin
            state_r <= IDLE;
            frame_o <= 1'b0;
          end
        end
        SHIFT: begin
          if (accept_s) begin
            state_r <= SHIFT;
            frame_o <= 1'b1;
          end else if (frame_end_s) begin
            state_r <= IDLE;
            frame_o <= 1'b0;
          end else begin
            state_r <= SHIFT;
            frame_o <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          frame_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux8_serializer_ctrl.sv
// Directed bench: three controller instances (C=4 LSB-first, C=4 MSB-first,
// C=1 LSB-first); y is modelled as the 8:1 mux selecting data_o[sel_o].
module tb_mux8_serializer_ctrl;

  logic            clk;
  logic            rst;
  logic [2:0][7:0] din;
  logic [2:0]      vld;
  logic [2:0]      rdy;
  logic [2:0][7:0] dat;
  logic [2:0][2:0] sel;
  logic [2:0]      frame;
  logic [2:0]      strobe;
  logic [2:0]      done;

  int n_checks;
  int n_fail;

  mux8_serializer_ctrl #(.CLKS_PER_BIT(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .in_data(din[0]), .in_valid(vld[0]), .in_ready(rdy[0]),
    .data_o(dat[0]), .sel_o(sel[0]), .frame_o(frame[0]),
    .bit_strobe_o(strobe[0]), .done_o(done[0])
  );

  mux8_serializer_ctrl #(.CLKS_PER_BIT(4), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .in_data(din[1]), .in_valid(vld[1]), .in_ready(rdy[1]),
    .data_o(dat[1]), .sel_o(sel[1]), .frame_o(frame[1]),
    .bit_strobe_o(strobe[1]), .done_o(done[1])
  );

  mux8_serializer_ctrl #(.CLKS_PER_BIT(1), .MSB_FIRST(1'b0)) u_c1 (
    .clk(clk), .rst(rst), .in_data(din[2]), .in_valid(vld[2]), .in_ready(rdy[2]),
    .data_o(dat[2]), .sel_o(sel[2]), .frame_o(frame[2]),
    .bit_strobe_o(strobe[2]), .done_o(done[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int i, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s inst%0d: observed %0h expected %0h", tag, i, obs, exp);
    end
  endtask

  // Gate-level mux stand-in: y = i[s].
  function automatic logic mux8(input logic [7:0] i_v, input logic [2:0] s_v);
    return i_v[s_v];
  endfunction

  task automatic start(input int i, input logic [7:0] b);
    vld[i] = 1'b1;
    din[i] = b;
    chk("start_ready", i, 8'(rdy[i]), 8'h01);
    tick();
    vld[i] = 1'b0;
    din[i] = 8'h00;
  endtask

  // Checks every cycle of one frame, optionally driving the next byte.
  task automatic run_frame(input int i, input logic [7:0] b, input int c, input bit msb,
                           input bit hold, input bit nv, input logic [7:0] nb,
                           input int ign, input bit df);
    logic [2:0] es;
    bit last;
    bit inj;
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < c; j++) begin
        es   = msb ? 3'(7 - k) : 3'(k);
        last = (k == 7) && (j == c - 1);
        inj  = (k == ign) && (j == 0);
        chk("sel", i, 8'(sel[i]), 8'(es));
        chk("y", i, 8'(mux8(dat[i], sel[i])), 8'(b[es]));
        chk("data", i, dat[i], b);
        chk("frame", i, 8'(frame[i]), 8'h01);
        chk("strobe", i, 8'(strobe[i]), (j == 0) ? 8'h01 : 8'h00);
        chk("done", i, 8'(done[i]), ((k == 0) && (j == 0) && df) ? 8'h01 : 8'h00);
        chk("ready", i, 8'(rdy[i]), last ? 8'h01 : 8'h00);
        vld[i] = last ? nv : (hold || inj);
        din[i] = last ? nb : (inj ? 8'hFF : b);
        tick();
        vld[i] = 1'b0;
      end
    end
  endtask

  task automatic end_check(input int i, input logic [2:0] st, input logic [7:0] b);
    chk("end_done", i, 8'(done[i]), 8'h01);
    chk("end_frame", i, 8'(frame[i]), 8'h00);
    chk("end_sel", i, 8'(sel[i]), 8'(st));
    chk("end_data", i, dat[i], b);
    chk("end_strobe", i, 8'(strobe[i]), 8'h00);
    chk("end_ready", i, 8'(rdy[i]), 8'h01);
    tick();
    chk("post_done", i, 8'(done[i]), 8'h00);
    chk("post_frame", i, 8'(frame[i]), 8'h00);
    chk("post_data", i, dat[i], b);
    tick();
    chk("idle_frame", i, 8'(frame[i]), 8'h00);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    vld      = 3'b000;
    din      = '0;
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("rst_data", i, dat[i], 8'h00);
      chk("rst_sel", i, 8'(sel[i]), (i == 1) ? 8'h07 : 8'h00);
      chk("rst_frame", i, 8'(frame[i]), 8'h00);
      chk("rst_strobe", i, 8'(strobe[i]), 8'h00);
      chk("rst_done", i, 8'(done[i]), 8'h00);
      chk("rst_ready", i, 8'(rdy[i]), 8'h00);
    end
    rst = 1'b0;
    #1;

    // LSB-first 0xA5 with a 0xFF pulse ignored during bit 3.
    start(0, 8'hA5);
    run_frame(0, 8'hA5, 4, 1'b0, 1'b0, 1'b0, 8'h00, 3, 1'b0);
    end_check(0, 3'd0, 8'hA5);

    // MSB-first 0x81.
    start(1, 8'h81);
    run_frame(1, 8'h81, 4, 1'b1, 1'b0, 1'b0, 8'h00, 8, 1'b0);
    end_check(1, 3'd7, 8'h81);

    // Back-to-back 0x3C then 0xC3 with in_valid held high.
    start(0, 8'h3C);
    run_frame(0, 8'h3C, 4, 1'b0, 1'b1, 1'b1, 8'hC3, 8, 1'b0);
    run_frame(0, 8'hC3, 4, 1'b0, 1'b0, 1'b0, 8'h00, 8, 1'b1);
    end_check(0, 3'd0, 8'hC3);

    // Reset during bit 3 of 0x5A, then a fresh frame.
    start(0, 8'h5A);
    for (int t = 0; t < 12; t++) tick();
    chk("mid_sel", 0, 8'(sel[0]), 8'h03);
    rst = 1'b1;
    tick();
    chk("mrst_frame", 0, 8'(frame[0]), 8'h00);
    chk("mrst_sel", 0, 8'(sel[0]), 8'h00);
    chk("mrst_data", 0, dat[0], 8'h00);
    chk("mrst_done", 0, 8'(done[0]), 8'h00);
    chk("mrst_strobe", 0, 8'(strobe[0]), 8'h00);
    rst = 1'b0;
    #1;
    for (int t = 0; t < 3; t++) begin
      tick();
      chk("mrst_nodone", 0, 8'(done[0]), 8'h00);
      chk("mrst_noframe", 0, 8'(frame[0]), 8'h00);
    end
    start(0, 8'h5A);
    run_frame(0, 8'h5A, 4, 1'b0, 1'b0, 1'b0, 8'h00, 8, 1'b0);
    end_check(0, 3'd0, 8'h5A);

    // One clock per bit, 0x0F.
    start(2, 8'h0F);
    run_frame(2, 8'h0F, 1, 1'b0, 1'b0, 1'b0, 8'h00, 8, 1'b0);
    end_check(2, 3'd0, 8'h0F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
